// File: rtl/mult_sequencer.sv
`default_nettype none
//============================================================================
// Module      : mult_sequencer
// Description : Pipeline-facing sequencer for the 32-cycle Booth multiplier.
//               Registers a multiply request, launches the multiplier with a
//               one-cycle do_mul pulse, waits for mul_value_ready, then holds
//               the low word and overflow flag for writeback behind a
//               valid/ready handshake. Stalls upstream while busy.
//               Optional feature macro: MULT_TIMEOUT_EN (aborts a multiply
//               that has waited TIMEOUT cycles, reporting an exception).
// Revision    : 1.0 - initial release
//============================================================================
module mult_sequencer #(
    parameter int MUL_LATENCY = 33,
    parameter int TIMEOUT     = 40
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        do_mul,
    input  logic        mul_value_ready,
    input  logic        mul_exception,
    input  logic [31:0] mul_out,
    output logic        stall,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_exception
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q;
    logic        do_mul_q;
    logic        wb_valid_q;
    logic        wb_exc_q;
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic [5:0]  cnt_q;
    logic [5:0]  cnt_d;

    // The wait counter is 6 bits wide, so the timeout must fit in it, and a
    // timeout no longer than the multiplier latency would abort every op.
    generate
        if (TIMEOUT < 1 || TIMEOUT > 63) begin : g_bad_timeout_range
            $error("mult_sequencer: TIMEOUT must lie in 1..63");
        end
        if (TIMEOUT <= MUL_LATENCY) begin : g_bad_timeout_latency
            $error("mult_sequencer: TIMEOUT must exceed MUL_LATENCY");
        end
    endgenerate

`ifdef MULT_TIMEOUT_EN
    localparam logic [5:0] c_TIMEOUT = 6'(TIMEOUT);
`endif

    // Handshake and stall are combinational so a finished result can be
    // retired and a new request taken in the same cycle.
    assign req_ready = (state_q == IDLE) | ((state_q == DONE) & wb_ready);
    assign stall     = (state_q == LAUNCH) | (state_q == WAIT)
                     | ((state_q == DONE) & ~wb_ready)
                     | (req_valid & ~req_ready);

    // Saturating increment of the wait counter; it must never wrap.
    assign cnt_d = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;

    assign do_mul       = do_mul_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_exception = wb_exc_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;

    // Sequencer FSM with registered launch pulse, operands and result.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            do_mul_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_exc_q   <= 1'b0;
            mul_a_q    <= 32'd0;
            mul_b_q    <= 32'd0;
            wb_data_q  <= 32'd0;
            wb_rd_q    <= 5'd0;
            cnt_q      <= 6'd0;
        end else if (flush) begin
            // Abort everything; a pending launch is dropped and any held
            // result is discarded. Operands stay until the next accept.
            state_q    <= IDLE;
            do_mul_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_exc_q   <= 1'b0;
            wb_data_q  <= 32'd0;
            cnt_q      <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mul_a_q  <= req_a;
                        mul_b_q  <= req_b;
                        wb_rd_q  <= req_rd;
                        do_mul_q <= 1'b1;
                        state_q  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Any mul_value_ready here belongs to an older op.
                    do_mul_q <= 1'b0;
                    cnt_q    <= 6'd0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (mul_value_ready) begin
                        wb_data_q  <= mul_out;
                        wb_exc_q   <= mul_exception;
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
`ifdef MULT_TIMEOUT_EN
                    else if (cnt_d >= c_TIMEOUT) begin
                        wb_data_q  <= 32'd0;
                        wb_exc_q   <= 1'b1;
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        if (req_valid) begin
                            mul_a_q  <= req_a;
                            mul_b_q  <= req_b;
                            wb_rd_q  <= req_rd;
                            do_mul_q <= 1'b1;
                            state_q  <= LAUNCH;
                        end else begin
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
